issue_scheduler: RTL and testbench

// In-order dual-issue scheduler between the 64-entry instruction queue and two execution units.

---
 rtl/issue_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_issue_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order dual-issue scheduler sitting between the instruction
// queue head and two execution units (FU0, FU1).
//
// Each cycle it looks at the two head entries and issues ready ones into the
// per-FU issue registers. It tells the queue how many entries it consumed
// (taken). A flush squashes both issue registers and blocks issue for a short
// drain window.
//
// Ports
//   clk, rst_n          clock / async active-low reset
//   flush               squash in-flight issue, enter FLUSH
//   head0, head1        queue entries: [56]valid [55:52]op [51:46]rob [45:40]lookA
//                       [39:34]lookB [33:18]valueA [17:2]valueB [1:0]user
//   taken               entries consumed this cycle (0..2, combinational)
//   fu0_ready/fu1_ready FU accepts its issue register this cycle
//   fuN_valid/op/rob/a/b issue register N contents
//   issued_count        saturating count of issued instructions
//   stall_count         saturating count of RUN cycles with head0 valid, nothing issued
//
// State | meaning
//   ST_RUN   | issue enabled
//   ST_FLUSH | issue disabled, drain counter running
module issue_scheduler #(
    parameter logic [3:0] FU1_OP_LIMIT = 4'hC,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [56:0]      head0,
    input  logic [56:0]      head1,
    output logic [1:0]       taken,
    input  logic             fu0_ready,
    input  logic             fu1_ready,
    output logic             fu0_valid,
    output logic [3:0]       fu0_op,
    output logic [5:0]       fu0_rob,
    output logic [15:0]      fu0_a,
    output logic [15:0]      fu0_b,
    output logic             fu1_valid,
    output logic [3:0]       fu1_op,
    output logic [5:0]       fu1_rob,
    output logic [15:0]      fu1_a,
    output logic [15:0]      fu1_b,
    output logic [CNT_W-1:0] issued_count,
    output logic [CNT_W-1:0] stall_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t          r_state, w_state_nxt;
    logic [FC_W-1:0] r_fcnt, w_fcnt_nxt;

    logic            r_fu0_valid, r_fu1_valid;
    logic [3:0]      r_fu0_op, r_fu1_op;
    logic [5:0]      r_fu0_rob, r_fu1_rob;
    logic [15:0]     r_fu0_a, r_fu0_b, r_fu1_a, r_fu1_b;
    logic [CNT_W-1:0] r_issued, r_stall;

    logic w_issue_en, w_h0_rdy, w_h1_rdy, w_free0, w_free1;
    logic w_h0_to0, w_h0_to1, w_h1_to0, w_h1_to1;
    logic w_load0, w_load1, w_stall;
    logic [56:0] w_src0, w_src1;
    logic [CNT_W:0] w_iss_sum;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        if (flush) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = FC_LOAD;
        end else if (r_state == ST_FLUSH) begin
            if (r_fcnt == '0) w_state_nxt = ST_RUN;
            else              w_fcnt_nxt  = r_fcnt - 1'b1;
        end
    end

    // ---------------- issue decision ----------------
    // rst_n gates issue so taken reads 0 while reset is held.
    assign w_issue_en = rst_n && (r_state == ST_RUN) && !flush;
    assign w_h0_rdy   = head0[56] && (head0[1:0] == 2'b00);
    assign w_h1_rdy   = head1[56] && (head1[1:0] == 2'b00);
    assign w_free0    = !r_fu0_valid || fu0_ready;
    assign w_free1    = !r_fu1_valid || fu1_ready;

    assign w_h0_to0 = w_issue_en && w_h0_rdy && w_free0;
    assign w_h0_to1 = w_issue_en && w_h0_rdy && !w_free0 && w_free1 &&
                      (head0[55:52] < FU1_OP_LIMIT);
    // head1 only follows head0 into whichever slot head0 left behind.
    assign w_h1_to1 = w_h0_to0 && w_h1_rdy && w_free1 && (head1[55:52] < FU1_OP_LIMIT);
    assign w_h1_to0 = w_h0_to1 && w_h1_rdy && w_free0;

    assign taken   = 2'(w_h0_to0 | w_h0_to1) + 2'(w_h1_to0 | w_h1_to1);
    assign w_load0 = w_h0_to0 || w_h1_to0;
    assign w_load1 = w_h0_to1 || w_h1_to1;
    assign w_src0  = w_h0_to0 ? head0 : head1;
    assign w_src1  = w_h0_to1 ? head0 : head1;
    assign w_stall = w_issue_en && head0[56] && (taken == 2'd0);

    // ---------------- issue registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fu0_valid <= 1'b0;
            r_fu0_op    <= '0;
            r_fu0_rob   <= '0;
            r_fu0_a     <= '0;
            r_fu0_b     <= '0;
            r_fu1_valid <= 1'b0;
            r_fu1_op    <= '0;
            r_fu1_rob   <= '0;
            r_fu1_a     <= '0;
            r_fu1_b     <= '0;
        end else begin
            if (flush) begin
                r_fu0_valid <= 1'b0;
            end else if (w_load0) begin
                r_fu0_valid <= 1'b1;
                r_fu0_op    <= w_src0[55:52];
                r_fu0_rob   <= w_src0[51:46];
                r_fu0_a     <= w_src0[33:18];
                r_fu0_b     <= w_src0[17:2];
            end else if (fu0_ready) begin
                r_fu0_valid <= 1'b0;
            end

            if (flush) begin
                r_fu1_valid <= 1'b0;
            end else if (w_load1) begin
                r_fu1_valid <= 1'b1;
                r_fu1_op    <= w_src1[55:52];
                r_fu1_rob   <= w_src1[51:46];
                r_fu1_a     <= w_src1[33:18];
                r_fu1_b     <= w_src1[17:2];
            end else if (fu1_ready) begin
                r_fu1_valid <= 1'b0;
            end
        end
    end

    // ---------------- performance counters ----------------
    assign w_iss_sum = {1'b0, r_issued} + (CNT_W+1)'(taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued <= '0;
            r_stall  <= '0;
        end else begin
            r_issued <= w_iss_sum[CNT_W] ? '1 : w_iss_sum[CNT_W-1:0];
            if (w_stall && (r_stall != '1)) r_stall <= r_stall + 1'b1;
        end
    end

    assign fu0_valid    = r_fu0_valid;
    assign fu0_op       = r_fu0_op;
    assign fu0_rob      = r_fu0_rob;
    assign fu0_a        = r_fu0_a;
    assign fu0_b        = r_fu0_b;
    assign fu1_valid    = r_fu1_valid;
    assign fu1_op       = r_fu1_op;
    assign fu1_rob      = r_fu1_rob;
    assign fu1_a        = r_fu1_a;
    assign fu1_b        = r_fu1_b;
    assign issued_count = r_issued;
    assign stall_count  = r_stall;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler. Counters are built 4 bits wide so
// saturation is reachable in a few cycles.
module tb_issue_scheduler;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [56:0]   head0, head1;
    logic [1:0]    taken;
    logic          fu0_ready, fu1_ready;
    logic          fu0_valid, fu1_valid;
    logic [3:0]    fu0_op, fu1_op;
    logic [5:0]    fu0_rob, fu1_rob;
    logic [15:0]   fu0_a, fu0_b, fu1_a, fu1_b;
    logic [CW-1:0] issued_count, stall_count;

    int checks = 0;
    int errors = 0;

    issue_scheduler #(.FU1_OP_LIMIT(4'hC), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .head0(head0), .head1(head1), .taken(taken),
        .fu0_ready(fu0_ready), .fu1_ready(fu1_ready),
        .fu0_valid(fu0_valid), .fu0_op(fu0_op), .fu0_rob(fu0_rob),
        .fu0_a(fu0_a), .fu0_b(fu0_b),
        .fu1_valid(fu1_valid), .fu1_op(fu1_op), .fu1_rob(fu1_rob),
        .fu1_a(fu1_a), .fu1_b(fu1_b),
        .issued_count(issued_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [56:0] h0;
        logic [56:0] h1;
        logic        r0;
        logic        r1;
        logic [1:0]  exp_taken;
        logic        v0;
        logic        v1;
        logic [5:0]  rob0;
        logic [5:0]  rob1;
        logic [3:0]  iss;
        logic [3:0]  stl;
    } vec_t;

    // Operand values are derived from the rob tag so each entry is distinguishable.
    function automatic logic [56:0] ent(input logic [3:0] op, input logic [5:0] rob,
                                        input logic [1:0] user, input logic v);
        return {v, op, rob, 6'd0, 6'd0, 16'hA000 | {10'd0, rob},
                16'hB000 | {10'd0, rob}, user};
    endfunction

    function automatic vec_t mkv(input logic fl, input logic [56:0] h0, input logic [56:0] h1,
                                 input logic r0, input logic r1, input logic [1:0] tk,
                                 input logic v0, input logic v1, input logic [5:0] rb0,
                                 input logic [5:0] rb1, input logic [3:0] iss,
                                 input logic [3:0] stl);
        vec_t t;
        t.flush = fl; t.h0 = h0; t.h1 = h1; t.r0 = r0; t.r1 = r1;
        t.exp_taken = tk; t.v0 = v0; t.v1 = v1; t.rob0 = rb0; t.rob1 = rb1;
        t.iss = iss; t.stl = stl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [56:0] h0, input logic [56:0] h1,
                         input logic r0, input logic r1);
        flush = fl; head0 = h0; head1 = h1; fu0_ready = r0; fu1_ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        tv[19];
    logic [56:0] none;

    initial begin
        none = ent(4'h0, 6'd0, 2'b00, 1'b0);
        //             fl  head0                  head1                  r0 r1 tk v0 v1 rob0 rob1 iss stl
        tv[0]  = mkv(0, ent(4'h1,  5,0,1),  ent(4'h2,  6,0,1),  0, 0, 2, 1, 1,  5,  6,  2, 0);
        tv[1]  = mkv(0, ent(4'h1,  7,2,1),  ent(4'h2,  8,0,1),  1, 1, 0, 0, 0,  5,  6,  2, 1);
        tv[2]  = mkv(0, ent(4'h1,  7,2,1),  ent(4'h2,  8,0,1),  1, 1, 0, 0, 0,  5,  6,  2, 2);
        tv[3]  = mkv(0, ent(4'h1,  7,0,1),  ent(4'h2,  8,0,1),  1, 1, 2, 1, 1,  7,  8,  4, 2);
        tv[4]  = mkv(0, ent(4'hD,  9,0,1),  ent(4'h1, 10,0,1),  0, 1, 0, 1, 0,  7,  8,  4, 3);
        tv[5]  = mkv(0, ent(4'h3, 11,0,1),  ent(4'h1, 12,0,1),  0, 1, 1, 1, 1,  7, 11,  5, 3);
        tv[6]  = mkv(0, none,               none,               1, 0, 0, 0, 1,  7, 11,  5, 3);
        tv[7]  = mkv(0, none,               none,               0, 0, 0, 0, 1,  7, 11,  5, 3);
        tv[8]  = mkv(0, none,               none,               0, 0, 0, 0, 1,  7, 11,  5, 3);
        tv[9]  = mkv(0, ent(4'h1, 14,0,1),  ent(4'h2, 15,0,1),  0, 1, 2, 1, 1, 14, 15,  7, 3);
        tv[10] = mkv(1, ent(4'h1, 16,0,1),  ent(4'h2, 17,0,1),  0, 0, 0, 0, 0, 14, 15,  7, 3);
        tv[11] = mkv(0, ent(4'h1, 16,0,1),  ent(4'h2, 17,0,1),  1, 1, 0, 0, 0, 14, 15,  7, 3);
        tv[12] = mkv(1, ent(4'h1, 16,0,1),  ent(4'h2, 17,0,1),  1, 1, 0, 0, 0, 14, 15,  7, 3);
        tv[13] = mkv(0, ent(4'h1, 16,0,1),  ent(4'h2, 17,0,1),  1, 1, 0, 0, 0, 14, 15,  7, 3);
        tv[14] = mkv(0, ent(4'h1, 16,0,1),  ent(4'h2, 17,0,1),  1, 1, 0, 0, 0, 14, 15,  7, 3);
        tv[15] = mkv(0, ent(4'h1, 16,0,1),  ent(4'h2, 17,0,1),  1, 1, 2, 1, 1, 16, 17,  9, 3);
        tv[16] = mkv(0, none,               ent(4'h1, 18,0,1),  1, 1, 0, 0, 0, 16, 17,  9, 3);
        tv[17] = mkv(0, ent(4'h1, 19,0,1),  ent(4'hE, 20,0,1),  1, 1, 1, 1, 0, 19, 17, 10, 3);
        tv[18] = mkv(0, none,               none,               1, 1, 0, 0, 0, 19, 17, 10, 3);

        rst_n = 1'b0;
        drive(1'b0, none, none, 1'b0, 1'b0);
        #12;
        rst_n = 1'b1;
        tick();

        chk("rst_fu0_valid", 32'(fu0_valid), 32'd0);
        chk("rst_fu1_valid", 32'(fu1_valid), 32'd0);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_issued", 32'(issued_count), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_fu0_rob", 32'(fu0_rob), 32'd0);

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].flush, tv[i].h0, tv[i].h1, tv[i].r0, tv[i].r1);
            #1;
            chk($sformatf("v%0d_taken", i), 32'(taken), 32'(tv[i].exp_taken));
            tick();
            chk($sformatf("v%0d_fu0_valid", i), 32'(fu0_valid), 32'(tv[i].v0));
            chk($sformatf("v%0d_fu1_valid", i), 32'(fu1_valid), 32'(tv[i].v1));
            chk($sformatf("v%0d_fu0_rob", i), 32'(fu0_rob), 32'(tv[i].rob0));
            chk($sformatf("v%0d_fu1_rob", i), 32'(fu1_rob), 32'(tv[i].rob1));
            chk($sformatf("v%0d_fu0_a", i), 32'(fu0_a), 32'(16'hA000 | {10'd0, tv[i].rob0}));
            chk($sformatf("v%0d_fu1_b", i), 32'(fu1_b), 32'(16'hB000 | {10'd0, tv[i].rob1}));
            chk($sformatf("v%0d_issued", i), 32'(issued_count), 32'(tv[i].iss));
            chk($sformatf("v%0d_stall", i), 32'(stall_count), 32'(tv[i].stl));
        end

        // issued_count saturation: 10 -> 12 -> 14 -> 15 -> 15
        drive(1'b0, ent(4'h1, 21, 0, 1), ent(4'h2, 22, 0, 1), 1'b1, 1'b1);
        tick(); chk("sat_iss_12", 32'(issued_count), 32'd12);
        tick(); chk("sat_iss_14", 32'(issued_count), 32'd14);
        tick(); chk("sat_iss_15", 32'(issued_count), 32'd15);
        tick(); chk("sat_iss_hold", 32'(issued_count), 32'd15);
        chk("sat_fu0_op", 32'(fu0_op), 32'h1);
        chk("sat_fu1_op", 32'(fu1_op), 32'h2);

        // stall_count saturation from 3
        drive(1'b0, ent(4'h1, 23, 2'b01, 1), none, 1'b1, 1'b1);
        for (int k = 0; k < 11; k++) tick();
        chk("sat_stall_14", 32'(stall_count), 32'd14);
        tick(); chk("sat_stall_15", 32'(stall_count), 32'd15);
        tick(); tick();
        chk("sat_stall_hold", 32'(stall_count), 32'd15);

        // async reset mid-issue: outputs clear without waiting for an edge
        drive(1'b0, ent(4'h1, 24, 0, 1), ent(4'h2, 25, 0, 1), 1'b0, 1'b0);
        tick();
        chk("pre_rst_fu0_valid", 32'(fu0_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_fu0_valid", 32'(fu0_valid), 32'd0);
        chk("arst_fu1_valid", 32'(fu1_valid), 32'd0);
        chk("arst_taken", 32'(taken), 32'd0);
        chk("arst_issued", 32'(issued_count), 32'd0);
        chk("arst_stall", 32'(stall_count), 32'd0);
        chk("arst_fu1_rob", 32'(fu1_rob), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
